// File: rtl/parallel_mult_rs.sv
// parallel_mult_rs: multi-lane signed fixed-point multiplier with rounding, saturation and a stallable 3-stage pipeline
module parallel_mult_rs #(
  parameter int PARALLEL_IN = 4,
  parameter int DATA1_WIDTH = 16,
  parameter int DATA1_INT   = 2,
  parameter int DATA2_WIDTH = 16,
  parameter int DATA2_INT   = 2,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_INT     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA1_WIDTH*PARALLEL_IN-1:0] din1,
  input  logic [DATA2_WIDTH*PARALLEL_IN-1:0] din2,
  input  logic                               din_valid,
  output logic                               din_ready,
  input  logic                               round_en,
  output logic [OUT_WIDTH*PARALLEL_IN-1:0]   dout,
  output logic                               dout_valid,
  input  logic                               dout_ready,
  output logic [PARALLEL_IN-1:0]             ovf,
  output logic [PARALLEL_IN-1:0]             ovf_sticky,
  input  logic                               clr_ovf
);
  localparam int FULL_WIDTH = DATA1_WIDTH + DATA2_WIDTH;
  localparam int FULL_POINT = (DATA1_WIDTH - DATA1_INT) + (DATA2_WIDTH - DATA2_INT);
  localparam int OUT_POINT  = OUT_WIDTH - OUT_INT;
  localparam int SHIFT      = FULL_POINT - OUT_POINT;
  localparam int EW         = FULL_WIDTH + 1;
  // half an output LSB, used only when there are bits to discard
  localparam logic [EW-1:0] RND = (SHIFT > 0) ? EW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [DATA1_WIDTH*PARALLEL_IN-1:0] s1_d1;
  logic [DATA2_WIDTH*PARALLEL_IN-1:0] s1_d2;
  logic                               s1_rnd;
  logic                               s1_valid;
  logic [FULL_WIDTH*PARALLEL_IN-1:0]  prod;
  logic [FULL_WIDTH*PARALLEL_IN-1:0]  s2_p;
  logic                               s2_rnd;
  logic                               s2_valid;
  logic [OUT_WIDTH*PARALLEL_IN-1:0]   res;
  logic [PARALLEL_IN-1:0]             ov;
  logic signed [EW-1:0]               ext;
  logic signed [EW-1:0]               sh;
  logic                               stall;
  logic                               hs;

  // the whole pipeline freezes only when a valid result is refused downstream
  assign stall     = dout_valid & ~dout_ready;
  assign hs        = dout_valid & dout_ready;
  assign din_ready = ~stall;

  // S1: capture operands and rounding mode with the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_d1    <= '0;
      s1_d2    <= '0;
      s1_rnd   <= 1'b0;
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_d1    <= din1;
      s1_d2    <= din2;
      s1_rnd   <= round_en;
      s1_valid <= din_valid;
    end
  end

  // full-precision signed product per lane; operands are sign-extended first so nothing is lost
  always_comb begin
    prod = '0;
    for (int i = 0; i < PARALLEL_IN; i++)
      prod[FULL_WIDTH*i +: FULL_WIDTH] = FULL_WIDTH'($signed(s1_d1[DATA1_WIDTH*i +: DATA1_WIDTH]))
                                       * FULL_WIDTH'($signed(s1_d2[DATA2_WIDTH*i +: DATA2_WIDTH]));
  end

  // S2: hold the products and carry the rounding mode alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_p     <= '0;
      s2_rnd   <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_p     <= prod;
      s2_rnd   <= s1_rnd;
      s2_valid <= s1_valid;
    end
  end

  // round in one extra bit so the carry cannot wrap, shift arithmetically, then clamp to the output range
  always_comb begin
    res = '0;
    ov  = '0;
    ext = '0;
    sh  = '0;
    for (int i = 0; i < PARALLEL_IN; i++) begin
      ext = {s2_p[FULL_WIDTH*(i+1)-1], s2_p[FULL_WIDTH*i +: FULL_WIDTH]} + (s2_rnd ? RND : '0);
      sh  = ext >>> SHIFT;
      ov[i] = (sh > MAXV) || (sh < MINV);
      res[OUT_WIDTH*i +: OUT_WIDTH] = (sh > MAXV) ? MAXV[OUT_WIDTH-1:0] :
                                      (sh < MINV) ? MINV[OUT_WIDTH-1:0] : sh[OUT_WIDTH-1:0];
    end
  end

  // S3: registered result and its per-lane saturation flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      ovf        <= '0;
      dout_valid <= 1'b0;
    end else if (!stall) begin
      dout       <= res;
      ovf        <= ov;
      dout_valid <= s2_valid;
    end
  end

  // sticky flags collect overflows of delivered beats; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky <= '0;
    else        ovf_sticky <= (clr_ovf ? '0 : ovf_sticky) | (ovf & {PARALLEL_IN{hs}});
  end
endmodule
